// File: rtl/mouse_accel_pos_if.sv
// Packet-in / cursor-out bundle for mouse_accel_pos.
//   master : drives the decoded PS/2 packet fields and the control inputs
//            (accel enable, recenter), and observes the cursor result.
//   slave  : the acceleration/position block itself.
// Input fields : i_pkt_valid, i_dx/i_dy (magnitude), i_x_sign/i_y_sign,
//                i_x_overflow/i_y_overflow, i_left/i_right, i_accel_en,
//                i_recenter.
// Output fields: o_valid, o_dx/o_dy (signed, DELTA_W), o_x/o_y (POS_W),
//                o_left/o_right.
interface mouse_accel_pos_if #(
    parameter int unsigned DELTA_W = 12,
    parameter int unsigned POS_W   = 10
);
    logic               i_pkt_valid;
    logic [7:0]         i_dx;
    logic [7:0]         i_dy;
    logic               i_x_sign;
    logic               i_y_sign;
    logic               i_x_overflow;
    logic               i_y_overflow;
    logic               i_left;
    logic               i_right;
    logic               i_accel_en;
    logic               i_recenter;

    logic               o_valid;
    logic [DELTA_W-1:0] o_dx;
    logic [DELTA_W-1:0] o_dy;
    logic [POS_W-1:0]   o_x;
    logic [POS_W-1:0]   o_y;
    logic               o_left;
    logic               o_right;

    modport master (
        output i_pkt_valid, i_dx, i_dy, i_x_sign, i_y_sign,
               i_x_overflow, i_y_overflow, i_left, i_right,
               i_accel_en, i_recenter,
        input  o_valid, o_dx, o_dy, o_x, o_y, o_left, o_right
    );

    modport slave (
        input  i_pkt_valid, i_dx, i_dy, i_x_sign, i_y_sign,
               i_x_overflow, i_y_overflow, i_left, i_right,
               i_accel_en, i_recenter,
        output o_valid, o_dx, o_dy, o_x, o_y, o_left, o_right
    );
endinterface

// File: rtl/mouse_accel_pos.sv
// Mouse acceleration and cursor position stage.
// Takes decoded PS/2 movement packets, applies a three-band piecewise gain
// per axis with sub-pixel residual carry, and integrates the result into a
// screen-clamped cursor position. Three-stage pipeline, one packet per cycle.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : mouse_accel_pos_if.slave (packet fields in, cursor result out)
module mouse_accel_pos #(
    parameter int unsigned FRAC_BITS = 4,
    parameter int unsigned GAIN_W    = 8,
    parameter int unsigned GAIN0     = 16,
    parameter int unsigned GAIN1     = 24,
    parameter int unsigned GAIN2     = 32,
    parameter int unsigned THR1      = 4,
    parameter int unsigned THR2      = 16,
    parameter int unsigned DELTA_W   = 12,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned POS_W     = 10,
    parameter bit          INVERT_Y  = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    mouse_accel_pos_if.slave bus
);

    // Accumulator must hold residual + 9-bit delta * gain, and also the
    // DELTA_W saturation bounds.
    localparam int unsigned ACC_RAW = 9 + GAIN_W + 2;
    localparam int unsigned ACC_W   = (ACC_RAW > DELTA_W + 1) ? ACC_RAW : DELTA_W + 1;
    localparam int unsigned P_W     = ((POS_W > DELTA_W) ? POS_W : DELTA_W) + 2;

    localparam logic signed [ACC_W-1:0] D_MAX = ACC_W'((2 ** (DELTA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] D_MIN = ~D_MAX;

    localparam logic signed [P_W-1:0] X_MAX = P_W'(SCREEN_W - 1);
    localparam logic signed [P_W-1:0] Y_MAX = P_W'(SCREEN_H - 1);
    localparam logic [POS_W-1:0]      X_CTR = POS_W'(SCREEN_W / 2);
    localparam logic [POS_W-1:0]      Y_CTR = POS_W'(SCREEN_H / 2);

    localparam logic [GAIN_W-1:0] G_UNITY = GAIN_W'(1 << FRAC_BITS);
    localparam logic [GAIN_W-1:0] G_BAND0 = GAIN_W'(GAIN0);
    localparam logic [GAIN_W-1:0] G_BAND1 = GAIN_W'(GAIN1);
    localparam logic [GAIN_W-1:0] G_BAND2 = GAIN_W'(GAIN2);
    localparam logic [8:0]        M_THR1  = 9'(THR1);
    localparam logic [8:0]        M_THR2  = 9'(THR2);

    // Overflow saturates to +/-255 (9-bit two's complement).
    localparam logic [8:0] SAT_POS = 9'h0FF;
    localparam logic [8:0] SAT_NEG = 9'h101;

    typedef struct packed {
        logic [DELTA_W-1:0]   delta;
        logic [FRAC_BITS-1:0] res;
    } gain_t;

    function automatic logic signed [8:0] form_delta(
        input logic [7:0] mag,
        input logic       sign,
        input logic       ovf
    );
        if (ovf) begin
            return sign ? SAT_NEG : SAT_POS;
        end
        return {sign, mag};
    endfunction

    // acc = residual + d*g; integer part is floor(acc / 2^FRAC_BITS) and the
    // low FRAC_BITS bits are the (always non-negative) carried residual.
    function automatic gain_t apply_gain(
        input logic signed [8:0]    d,
        input logic [FRAC_BITS-1:0] res,
        input logic                 en
    );
        logic [8:0]              m;
        logic [GAIN_W-1:0]       g;
        logic signed [ACC_W-1:0] d_ext;
        logic signed [ACC_W-1:0] g_ext;
        logic signed [ACC_W-1:0] r_ext;
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] q;
        gain_t                   r;

        m = d[8] ? (~d + 9'd1) : d;
        if (!en) begin
            g = G_UNITY;
        end else if (m < M_THR1) begin
            g = G_BAND0;
        end else if (m < M_THR2) begin
            g = G_BAND1;
        end else begin
            g = G_BAND2;
        end

        d_ext = {{(ACC_W - 9){d[8]}}, d};
        g_ext = {{(ACC_W - GAIN_W){1'b0}}, g};
        r_ext = {{(ACC_W - FRAC_BITS){1'b0}}, res};
        acc   = r_ext + d_ext * g_ext;
        q     = acc >>> FRAC_BITS;

        if (q > D_MAX) begin
            r.delta = D_MAX[DELTA_W-1:0];
        end else if (q < D_MIN) begin
            r.delta = D_MIN[DELTA_W-1:0];
        end else begin
            r.delta = q[DELTA_W-1:0];
        end
        r.res = acc[FRAC_BITS-1:0];
        return r;
    endfunction

    function automatic logic [POS_W-1:0] clamp_pos(
        input logic signed [P_W-1:0] v,
        input logic signed [P_W-1:0] hi
    );
        if (v[P_W-1]) begin
            return '0;
        end else if (v > hi) begin
            return hi[POS_W-1:0];
        end
        return v[POS_W-1:0];
    endfunction

    // Stage 1: formed 9-bit deltas
    logic                 s1_valid_q, s1_valid_d;
    logic signed [8:0]    s1_dx_q, s1_dx_d;
    logic signed [8:0]    s1_dy_q, s1_dy_d;
    logic                 s1_left_q, s1_left_d;
    logic                 s1_right_q, s1_right_d;

    // Stage 2: accelerated deltas and per-axis residuals
    logic                 s2_valid_q, s2_valid_d;
    logic [DELTA_W-1:0]   s2_dx_q, s2_dx_d;
    logic [DELTA_W-1:0]   s2_dy_q, s2_dy_d;
    logic                 s2_left_q, s2_left_d;
    logic                 s2_right_q, s2_right_d;
    logic [FRAC_BITS-1:0] res_x_q, res_x_d;
    logic [FRAC_BITS-1:0] res_y_q, res_y_d;

    // Stage 3: registered outputs and cursor position
    logic                 o_valid_q, o_valid_d;
    logic [DELTA_W-1:0]   o_dx_q, o_dx_d;
    logic [DELTA_W-1:0]   o_dy_q, o_dy_d;
    logic                 o_left_q, o_left_d;
    logic                 o_right_q, o_right_d;
    logic [POS_W-1:0]     pos_x_q, pos_x_d;
    logic [POS_W-1:0]     pos_y_q, pos_y_d;

    logic                 clr_res;
    logic [FRAC_BITS-1:0] res_x_use;
    logic [FRAC_BITS-1:0] res_y_use;
    gain_t                gx;
    gain_t                gy;
    logic signed [P_W-1:0] px_ext;
    logic signed [P_W-1:0] py_ext;
    logic signed [P_W-1:0] dx_ext;
    logic signed [P_W-1:0] dy_ext;
    logic signed [P_W-1:0] nx;
    logic signed [P_W-1:0] ny;

    always_comb begin
        // Stage 1
        s1_valid_d = bus.i_pkt_valid;
        s1_dx_d    = form_delta(bus.i_dx, bus.i_x_sign, bus.i_x_overflow);
        s1_dy_d    = form_delta(bus.i_dy, bus.i_y_sign, bus.i_y_overflow);
        s1_left_d  = bus.i_left;
        s1_right_d = bus.i_right;

        // Stage 2: recenter or disabled acceleration zeroes the residual seen
        // by the packet in this stage, and discards the residual it produces.
        clr_res   = bus.i_recenter || !bus.i_accel_en;
        res_x_use = clr_res ? '0 : res_x_q;
        res_y_use = clr_res ? '0 : res_y_q;
        gx        = apply_gain(s1_dx_q, res_x_use, bus.i_accel_en);
        gy        = apply_gain(s1_dy_q, res_y_use, bus.i_accel_en);

        s2_valid_d = s1_valid_q;
        s2_dx_d    = gx.delta;
        s2_dy_d    = gy.delta;
        s2_left_d  = s1_left_q;
        s2_right_d = s1_right_q;

        res_x_d = res_x_q;
        res_y_d = res_y_q;
        if (s1_valid_q) begin
            res_x_d = gx.res;
            res_y_d = gy.res;
        end
        if (clr_res) begin
            res_x_d = '0;
            res_y_d = '0;
        end

        // Stage 3: widened arithmetic so the sum cannot wrap before clamping
        px_ext = {{(P_W - POS_W){1'b0}}, pos_x_q};
        py_ext = {{(P_W - POS_W){1'b0}}, pos_y_q};
        dx_ext = {{(P_W - DELTA_W){s2_dx_q[DELTA_W-1]}}, s2_dx_q};
        dy_ext = {{(P_W - DELTA_W){s2_dy_q[DELTA_W-1]}}, s2_dy_q};
        nx     = px_ext + dx_ext;
        ny     = INVERT_Y ? (py_ext - dy_ext) : (py_ext + dy_ext);

        o_valid_d = s2_valid_q;
        o_dx_d    = o_dx_q;
        o_dy_d    = o_dy_q;
        o_left_d  = o_left_q;
        o_right_d = o_right_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        if (s2_valid_q) begin
            o_dx_d    = s2_dx_q;
            o_dy_d    = s2_dy_q;
            o_left_d  = s2_left_q;
            o_right_d = s2_right_q;
            pos_x_d   = clamp_pos(nx, X_MAX);
            pos_y_d   = clamp_pos(ny, Y_MAX);
        end
        // Recenter overrides a coinciding packet's position update only;
        // the packet still reports its deltas and strobes o_valid.
        if (bus.i_recenter) begin
            pos_x_d = X_CTR;
            pos_y_d = Y_CTR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_left_q  <= 1'b0;
            s1_right_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_dx_q    <= '0;
            s2_dy_q    <= '0;
            s2_left_q  <= 1'b0;
            s2_right_q <= 1'b0;
            res_x_q    <= '0;
            res_y_q    <= '0;
            o_valid_q  <= 1'b0;
            o_dx_q     <= '0;
            o_dy_q     <= '0;
            o_left_q   <= 1'b0;
            o_right_q  <= 1'b0;
            pos_x_q    <= X_CTR;
            pos_y_q    <= Y_CTR;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_dx_q    <= s1_dx_d;
            s1_dy_q    <= s1_dy_d;
            s1_left_q  <= s1_left_d;
            s1_right_q <= s1_right_d;
            s2_valid_q <= s2_valid_d;
            s2_dx_q    <= s2_dx_d;
            s2_dy_q    <= s2_dy_d;
            s2_left_q  <= s2_left_d;
            s2_right_q <= s2_right_d;
            res_x_q    <= res_x_d;
            res_y_q    <= res_y_d;
            o_valid_q  <= o_valid_d;
            o_dx_q     <= o_dx_d;
            o_dy_q     <= o_dy_d;
            o_left_q   <= o_left_d;
            o_right_q  <= o_right_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_dx    = o_dx_q;
    assign bus.o_dy    = o_dy_q;
    assign bus.o_x     = pos_x_q;
    assign bus.o_y     = pos_y_q;
    assign bus.o_left  = o_left_q;
    assign bus.o_right = o_right_q;

endmodule

// File: doc/mouse_accel_pos.md
Name: mouse_accel_pos

Overview:
Parametrised successor to the fixed-width mouse acceleration stage. It takes decoded PS/2 movement packets from mouse_driver and applies a three-band piecewise acceleration gain per axis. Sub-pixel remainders carry between packets. The result is integrated into a screen-clamped cursor position, emitted together with the accelerated deltas and the button state. It sits between mouse_driver and the display/cursor logic.

Parameters:
FRAC_BITS, 4, fractional bits of gain and residual (Q.FRAC_BITS)
GAIN_W, 8, gain word width, unsigned
GAIN0, 16, gain for |d| < THR1 (1.0)
GAIN1, 24, gain for THR1 <= |d| < THR2 (1.5)
GAIN2, 32, gain for |d| >= THR2 (2.0)
THR1, 4, lower magnitude threshold
THR2, 16, upper magnitude threshold
DELTA_W, 12, signed width of o_dx/o_dy
SCREEN_W, 640, horizontal extent in pixels
SCREEN_H, 480, vertical extent in pixels
POS_W, 10, width of o_x/o_y
INVERT_Y, 1, 1: screen y = pos_y - dy (PS/2 up = positive)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_pkt_valid  in  1  one-cycle packet strobe from mouse_driver
i_dx, i_dy  in  8  magnitude bits of the 9-bit two's-complement delta
i_x_sign, i_y_sign  in  1  sign bits (bit 8)
i_x_overflow, i_y_overflow  in  1  packet overflow flags
i_left, i_right  in  1  button state
i_accel_en  in  1  0: unity gain, residuals held at 0
i_recenter  in  1  pulse: cursor to centre, residuals cleared
o_valid  out  1  result strobe
o_dx, o_dy  out  DELTA_W  signed accelerated deltas, pre-inversion
o_x  out  POS_W  cursor x, 0..SCREEN_W-1
o_y  out  POS_W  cursor y, 0..SCREEN_H-1
o_left, o_right  out  1  buttons aligned with o_valid

Behaviour:
- Reset is synchronous and active-low on rst_n, sampled at the clk edge. While rst_n=0: o_valid=0, o_dx=o_dy=0, o_x=SCREEN_W/2, o_y=SCREEN_H/2, o_left=o_right=0, both residuals=0, pipeline valids=0.
- Fully pipelined with 3 stages. o_valid pulses exactly 3 cycles after i_pkt_valid. Back-to-back packets on every cycle are accepted with no stall.
- S1 (form delta): d = signed {sign, mag}, a 9-bit value. If the overflow flag is set, d saturates to +255 when sign=0 and to -255 when sign=1; mag is ignored.
- S2 (gain):
  - m = |d|. g = GAIN0 if m < THR1, GAIN1 if m < THR2, else GAIN2. g = 1<<FRAC_BITS when i_accel_en=0.
  - acc = residual + d*g, computed full-width signed.
  - int = acc >>> FRAC_BITS (arithmetic, floor toward -inf).
  - new residual = acc[FRAC_BITS-1:0], always non-negative.
  - int saturates to the DELTA_W signed range.
  - When i_accel_en=0, the residual is forced to 0.
- S3 (integrate):
  - x' = pos_x + dx, clamped to [0, SCREEN_W-1].
  - y' = pos_y - dy (INVERT_Y=1) or pos_y + dy, clamped to [0, SCREEN_H-1].
  - Arithmetic uses signed width max(POS_W, DELTA_W)+2, so no wrap-around is possible.
  - o_dx/o_dy/o_left/o_right are registered with o_valid and hold their values until the next o_valid.
- i_recenter takes effect on the next edge: position goes to centre and both residuals clear.
  - If it coincides with a packet in S3, recenter wins. o_valid still pulses, and o_x/o_y show the centre.
  - Packets in S1/S2 on that cycle use residual 0.
- Reset mid-pipeline discards all in-flight packets. No o_valid is produced for them.
- Axes are fully independent. Overflow on one axis does not affect the other.

Test Plan:
1. Reset, accel on, dx=+3 → after 3 clk: o_valid=1, o_dx=3, o_x=323, o_y=240.
2. dx=+5 twice back-to-back (gain 1.5, 7.5 px each) → o_dx=7 then 8; o_x=327 then 335; residual returns to 0.
3. dx=-5 twice → o_dx=-8 then -7; o_x=312 then 305 (floor rounding, non-negative residual).
4. dy=+20 (gain 2.0) → o_dy=40, o_y=200. Then i_y_overflow=1, sign=0 → o_dy=510, o_y clamps to 0.
5. Start at x=638, dx=+20 → o_x=639. Then dx=-255 with overflow, sign=1 → o_dx=-510, o_x=129.
6. Packet in S3 with i_recenter=1 → o_valid=1, o_x=320, o_y=240. Next packet dx=+5 uses residual 0 → o_dx=7. With i_accel_en=0, dx=+20 → o_dx=20.
